// File: rtl/i2s_mic_capture.sv
// I2S microphone capture: synchronises the asynchronous I2S bus into clk_clk,
// deserialises left/right words and buffers complete stereo frames in a FIFO.
module i2s_mic_capture #(
  parameter int WORD_W     = 16,
  parameter int FIFO_DEPTH = 4   // power of two, >= 2
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          sck,
  input  logic                          ws,
  input  logic                          sd,
  input  logic                          out_ready,
  input  logic                          ovf_clr,
  output logic                          out_valid,
  output logic [WORD_W-1:0]             out_left,
  output logic [WORD_W-1:0]             out_right,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WORD_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(WORD_W - 1);
  localparam logic [FW-1:0] FULL_CNT = FW'(FIFO_DEPTH);

  typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} chan_e;

  // Synchroniser and edge-detect flops
  logic sck_s1_q, sck_s2_q, sck_dly_q;
  logic ws_s1_q, ws_s2_q;
  logic sd_s1_q, sd_s2_q;
  logic tick;

  // Deserialiser state
  logic              ws_prev_q, ws_prev_d;
  chan_e             channel_q, channel_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] left_hold_q, left_hold_d;
  logic              left_ok_q, left_ok_d;
  logic              armed_q, armed_d;
  logic              push_q, push_d;
  logic [2*WORD_W-1:0] frame_q, frame_d;
  logic [WORD_W-1:0] word;

  // FIFO state
  logic [2*WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic              ovf_q, ovf_d;
  logic              pop, full, do_write, ovf_evt;
  logic [2*WORD_W-1:0] head;

  // Two-flop synchronisers plus a delayed sck copy for rising-edge detection
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_dly_q <= 1'b0;
      ws_s1_q   <= 1'b0;
      ws_s2_q   <= 1'b0;
      sd_s1_q   <= 1'b0;
      sd_s2_q   <= 1'b0;
    end else begin
      sck_s1_q  <= sck;
      sck_s2_q  <= sck_s1_q;
      sck_dly_q <= sck_s2_q;
      ws_s1_q   <= ws;
      ws_s2_q   <= ws_s1_q;
      sd_s1_q   <= sd;
      sd_s2_q   <= sd_s1_q;
    end
  end

  assign tick = sck_s2_q & ~sck_dly_q;
  assign word = {shift_q[WORD_W-2:0], sd_s2_q};

  // Serial deserialiser: slot alignment, word assembly and frame pairing.
  // Shifting is held off until a ws transition has been observed, so data
  // following reset is never taken from a slot of unknown alignment.
  always_comb begin
    ws_prev_d   = ws_prev_q;
    channel_d   = channel_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    armed_d     = armed_q;
    push_d      = 1'b0;
    frame_d     = frame_q;
    if (tick) begin
      if (ws_s2_q != ws_prev_q) begin
        ws_prev_d = ws_s2_q;
        channel_d = chan_e'(ws_s2_q);
        bit_cnt_d = '0;
        armed_d   = 1'b1;
      end else if (armed_q && (bit_cnt_q < CNT_MAX)) begin
        shift_d   = word;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == CNT_LAST) begin
          if (channel_q == CH_LEFT) begin
            left_hold_d = word;
            left_ok_d   = 1'b1;
          end else if (left_ok_q) begin
            push_d    = 1'b1;
            frame_d   = {left_hold_q, word};
            left_ok_d = 1'b0;
          end
        end
      end
    end
  end

  // Deserialiser state register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ws_prev_q   <= 1'b0;
      channel_q   <= CH_LEFT;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      armed_q     <= 1'b0;
      push_q      <= 1'b0;
      frame_q     <= '0;
    end else begin
      ws_prev_q   <= ws_prev_d;
      channel_q   <= channel_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      armed_q     <= armed_d;
      push_q      <= push_d;
      frame_q     <= frame_d;
    end
  end

  assign out_valid = (fill_q != '0);
  assign pop       = out_valid & out_ready;
  assign full      = (fill_q == FULL_CNT);
  assign do_write  = push_q & (~full | pop);
  assign ovf_evt   = push_q & full & ~pop;

  // FIFO pointer, occupancy and sticky overflow next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    ovf_d    = ovf_q;
    if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_write, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
    if (ovf_evt)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // FIFO control register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
    end
  end

  // Frame storage; contents are only observable through out_valid-gated outputs
  always_ff @(posedge clk_clk) begin
    if (do_write) mem_q[wr_ptr_q] <= frame_q;
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_left  = out_valid ? head[2*WORD_W-1:WORD_W] : '0;
  assign out_right = out_valid ? head[WORD_W-1:0]        : '0;
  assign fill      = fill_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_i2s_mic_capture.sv
// Scoreboard bench for i2s_mic_capture: directed I2S frames, expected frames
// queued at stimulus time, a monitor compares every accepted output frame.
module tb_i2s_mic_capture;

  localparam int W = 16;
  localparam int D = 4;

  logic           clk_clk = 1'b0;
  logic           reset_reset_n = 1'b0;
  logic           sck = 1'b0;
  logic           ws = 1'b1;
  logic           sd = 1'b0;
  logic           out_ready = 1'b0;
  logic           ovf_clr = 1'b0;
  logic           out_valid;
  logic [W-1:0]   out_left, out_right;
  logic [$clog2(D):0] fill;
  logic           overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  logic [2*W-1:0] exp_q [$];

  i2s_mic_capture #(.WORD_W(W), .FIFO_DEPTH(D)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .sck           (sck),
    .ws            (ws),
    .sd            (sd),
    .out_ready     (out_ready),
    .ovf_clr       (ovf_clr),
    .out_valid     (out_valid),
    .out_left      (out_left),
    .out_right     (out_right),
    .fill          (fill),
    .overflow      (overflow)
  );

  always #10 clk_clk = ~clk_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  // One sck period (16 clocks); data changes while sck is low. With pulse set,
  // out_ready is raised for exactly the cycle in which the DUT pushes the frame.
  task automatic send_bit(input logic w, input logic d, input bit pulse);
    sck = 1'b0; ws = w; sd = d;
    idle(8);
    sck = 1'b1;
    if (pulse) begin
      idle(3);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      idle(4);
    end else begin
      idle(8);
    end
  endtask

  task automatic send_word(input logic w, input logic [W-1:0] data, input int extra, input bit pulse);
    send_bit(w, 1'b0, 1'b0);
    for (int i = W - 1; i >= 0; i--) send_bit(w, data[i], pulse && (i == 0));
    for (int i = 0; i < extra; i++) send_bit(w, 1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input bit expect_it,
                            input int extra, input bit pulse);
    if (expect_it) exp_q.push_back({l, r});
    send_word(1'b0, l, extra, 1'b0);
    send_word(1'b1, r, extra, pulse);
  endtask

  task automatic prime();
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
  endtask

  task automatic wait_fill(input logic [31:0] target, input int max_cycles, input string name);
    int k = 0;
    while ((fill !== target[$clog2(D):0]) && (k < max_cycles)) begin
      idle(1);
      k++;
    end
    check(name, 32'(fill), target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},    32'(out_valid), 32'h0);
    check({tag, "_fill"},     32'(fill),      32'h0);
    check({tag, "_overflow"}, 32'(overflow),  32'h0);
    check({tag, "_left"},     32'(out_left),  32'h0);
    check({tag, "_right"},    32'(out_right), 32'h0);
  endtask

  // Monitor: every accepted frame must match the oldest expected frame
  initial begin
    logic [2*W-1:0] e;
    forever begin
      @(negedge clk_clk);
      if (reset_reset_n && out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pop: got 0x%0h, expected no frame", {out_left, out_right});
        end else begin
          e = exp_q.pop_front();
          n_pops++;
          if ({out_left, out_right} !== e) begin
            n_fail++;
            $display("FAIL frame_%0d: got 0x%0h, expected 0x%0h", n_pops, {out_left, out_right}, e);
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end");
    $fatal(1);
  end

  initial begin
    // Reset state
    idle(5);
    check_reset_outputs("reset");
    reset_reset_n = 1'b1;
    idle(2);
    prime();

    // Basic frame, consumer always ready
    out_ready = 1'b1;
    send_frame(16'hA5C3, 16'h1234, 1'b1, 0, 1'b0);
    idle(10);
    check("basic_pops", 32'(n_pops), 32'd1);
    check("basic_fill", 32'(fill), 32'd0);

    // 32-bit slots: trailing ones ignored
    send_frame(16'h8001, 16'h7FFE, 1'b1, 16, 1'b0);
    idle(10);
    check("slot32_pops", 32'(n_pops), 32'd2);

    // Overflow: five frames into a stalled four-deep FIFO, fifth dropped
    out_ready = 1'b0;
    send_frame(16'h0101, 16'h1010, 1'b1, 0, 1'b0);
    send_frame(16'h0202, 16'h2020, 1'b1, 0, 1'b0);
    send_frame(16'h0303, 16'h3030, 1'b1, 0, 1'b0);
    send_frame(16'h0404, 16'h4040, 1'b1, 0, 1'b0);
    send_frame(16'h0505, 16'h5050, 1'b0, 0, 1'b0);
    idle(10);
    check("ovf_fill", 32'(fill), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head_left", 32'(out_left), 32'h0101);
    check("ovf_head_right", 32'(out_right), 32'h1010);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("ovf_clear", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    wait_fill(32'd0, 50, "ovf_drain_fill");
    check("ovf_drain_pops", 32'(n_pops), 32'd6);

    // Full FIFO with a pop in the push cycle: nothing dropped
    out_ready = 1'b0;
    send_frame(16'h1111, 16'hAAAA, 1'b1, 0, 1'b0);
    send_frame(16'h2222, 16'hBBBB, 1'b1, 0, 1'b0);
    send_frame(16'h3333, 16'hCCCC, 1'b1, 0, 1'b0);
    send_frame(16'h4444, 16'hDDDD, 1'b1, 0, 1'b0);
    idle(10);
    check("full_fill_before", 32'(fill), 32'd4);
    send_frame(16'h5555, 16'hEEEE, 1'b1, 0, 1'b1);
    idle(10);
    check("full_pushpop_fill", 32'(fill), 32'd4);
    check("full_pushpop_ovf", 32'(overflow), 32'd0);
    check("full_pushpop_pops", 32'(n_pops), 32'd7);
    out_ready = 1'b1;
    wait_fill(32'd0, 50, "full_drain_fill");
    check("full_drain_pops", 32'(n_pops), 32'd11);

    // Short left word then a lone right word: no frame
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1, 1'b0);
    send_word(1'b1, 16'hBEEF, 0, 1'b0);
    idle(10);
    check("orphan_fill", 32'(fill), 32'd0);
    check("orphan_pops", 32'(n_pops), 32'd11);
    send_frame(16'h1357, 16'h2468, 1'b1, 0, 1'b0);
    idle(10);
    check("orphan_recover_pops", 32'(n_pops), 32'd12);

    // Reset after ten right bits; only the post-reset frame may emerge
    send_word(1'b0, 16'h9999, 0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1, 1'b0);
    reset_reset_n = 1'b0;
    idle(3);
    check_reset_outputs("midreset");
    reset_reset_n = 1'b1;
    idle(2);
    prime();
    send_frame(16'h0F0F, 16'hF0F0, 1'b1, 0, 1'b0);
    idle(10);
    check("midreset_pops", 32'(n_pops), 32'd13);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_mic_capture.md
I2S_MIC_CAPTURE -- requirements
Module: i2s_mic_capture

Interface
REQ-001 SHALL have parameter WORD_W, default 16, meaning the sample width captured per channel.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of stereo frames buffered (power of two).
REQ-003 SHALL have port clk_clk  input  1  system clock (50 MHz), the only clock.
REQ-004 SHALL have port reset_reset_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port sck  input  1  I2S bit clock from the mic, asynchronous to clk_clk.
REQ-006 SHALL have port ws  input  1  I2S word select; 0 = left, 1 = right; asynchronous.
REQ-007 SHALL have port sd  input  1  I2S serial data, MSB first; asynchronous.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the head frame.
REQ-009 SHALL have port ovf_clr  input  1  clears the sticky overflow flag.
REQ-010 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-011 SHALL have port out_left  output  WORD_W  left sample of the head frame.
REQ-012 SHALL have port out_right  output  WORD_W  right sample of the head frame.
REQ-013 SHALL have port fill  output  clog2(FIFO_DEPTH)+1  number of frames currently stored.
REQ-014 SHALL have port overflow  output  1  sticky flag; a frame was dropped.

Function
REQ-015 SHALL synchronise sck, ws and sd through 2 flops each, and SHALL register synchronised sck once more for edge detection.
REQ-016 SHALL generate a one-cycle tick when synchronised sck is 1 and its delayed copy is 0; all serial logic SHALL advance only on a tick.
REQ-017 SHALL require clk_clk >= 8x the sck frequency; behaviour below that ratio is unspecified.
REQ-018 On a tick where synchronised ws differs from the stored ws_prev: ws_prev <= ws, channel <= ws, bit_cnt <= 0, and no data bit is taken (I2S one-bit delay slot).
REQ-019 On a tick with ws unchanged and bit_cnt < WORD_W: shift sd into the shift register LSB, then bit_cnt += 1.
REQ-020 On a tick with bit_cnt = WORD_W: no action; extra bits (24/32-bit slots) are ignored; bit_cnt saturates.
REQ-021 A word is complete on the tick that shifts bit number WORD_W-1 (bit_cnt 15 -> 16 for the default width).
REQ-022 Left word complete: left_hold <= word, left_ok <= 1; a second left word without an intervening right word overwrites left_hold.
REQ-023 Right word complete with left_ok = 1: push {left_hold, word} in the next cycle, and left_ok <= 0.
REQ-024 Right word complete with left_ok = 0: the word is discarded; no push.
REQ-025 A ws change before bit_cnt reaches WORD_W SHALL discard the partial word silently (no push, left_ok unchanged).
REQ-026 FIFO: circular buffer with read/write pointers; out_valid = (fill != 0); out_left/out_right driven from the head entry, stable while out_valid = 1 and out_ready = 0.
REQ-027 Pop occurs when out_valid = 1 and out_ready = 1; the next entry (if any) is presented the following cycle.
REQ-028 Push latency: out_valid rises the cycle after the push cycle when the FIFO was empty.
REQ-029 Push when full without a simultaneous pop: the frame is dropped, overflow <= 1, and the FIFO contents are unchanged.
REQ-030 Simultaneous push and pop when full: both occur, fill stays FIFO_DEPTH, and no overflow is flagged.
REQ-031 Simultaneous push and pop when fill = 1: fill stays 1, and the new frame becomes the head.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH; fill SHALL range 0..FIFO_DEPTH.
REQ-033 ovf_clr = 1 SHALL clear overflow, except that an overflow event in the same cycle takes priority and sets it.

Reset
REQ-034 While reset_reset_n = 0: all synchroniser flops, ws_prev, channel, bit_cnt, shift register, left_hold, left_ok, pointers and fill SHALL be 0.
REQ-035 While reset_reset_n = 0: out_valid, out_left, out_right, fill and overflow SHALL be 0.
REQ-036 Reset asserted mid-word or mid-frame SHALL discard all partial data; the first frame after release SHALL be taken only after a full ws low->high sequence.

Verification
REQ-037 Scenario basic: sck = clk/16, one frame L = 0xA5C3, R = 0x1234, out_ready = 1 -> exactly one pop with out_left = 0xA5C3, out_right = 0x1234.
REQ-038 Scenario 32-bit slots: frame L = 0x8001 followed by 16 bits of 1s, R = 0x7FFE followed by 16 bits of 1s -> frame {0x8001, 0x7FFE}, with the trailing bits ignored.
REQ-039 Scenario overflow: out_ready = 0, 5 frames sent -> fill = 4, overflow = 1, and a drain returns frames 1-4 in order.
REQ-040 Scenario full with simultaneous push/pop: fill = 4 and out_ready pulsed in the push cycle -> fill = 4, overflow = 0.
REQ-041 Scenario short/orphan words: ws toggles after 8 left bits, then a lone right word is sent -> no push, and fill = 0.
REQ-042 Scenario reset mid-frame: reset asserted after 10 right bits, then released, then a full frame {0x0F0F, 0xF0F0} sent -> only {0x0F0F, 0xF0F0} emerges.
